contador_descendente: RTL and testbench

Loadable down-counter/timer with clock enable. It is the decrementing counterpart of the team's free-running up-counter.
- Software or an upstream FSM loads a start value, issues a start, and the block counts down once per enabled cycle to zero.
- On reaching zero it raises a one-cycle terminal-count pulse, then either stops (one-shot) or reloads (periodic).
- It sits beside the up-counter in the timing/sequencing layer and drives delay and timeout generation.

---
 rtl/contador_pkg.sv | 12 +
 rtl/contador_descendente.sv | 120 ++++++++++++
 tb/tb_contador_descendente.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package contador_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : contador_pkg

// File: rtl/contador_descendente.sv
// Loadable down-counter/timer with clock enable, one-cycle terminal-count
// pulse and optional periodic reload.
module contador_descendente
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH_DEF,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             iCE,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iValor,
  input  logic             iStart,
  input  logic             iStop,
  output logic [WIDTH-1:0] oSalidas,
  output logic             oBusy,
  output logic             oTC,
  output logic             oDone
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_prev_q;
  logic             start_edge;

  // Start acts on its rising edge so a held strobe cannot retrigger from DONE.
  assign start_edge = iStart & ~start_prev_q;

  // State, count and registered outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      reload_q     <= '0;
      tc_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      tc_q         <= tc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      start_prev_q <= iStart;
    end
  end

  // Next state / next count; priority is load > stop > start > enable.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (iLoad) begin
      count_d  = iValor;
      reload_d = iValor;
      state_d  = IDLE;
    end else if (iStop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              tc_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (iCE) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              if ((AUTO_RELOAD != 0) && (reload_q != '0)) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          if (start_edge) begin
            count_d = reload_q;
            if (reload_q != '0) begin
              state_d = RUN;
            end else begin
              tc_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign oSalidas = count_q;
  assign oBusy    = busy_q;
  assign oTC      = tc_q;
  assign oDone    = done_q;

endmodule : contador_descendente

// File: tb/tb_contador_descendente.sv
// Directed bench for contador_descendente: one-shot and periodic instances.
module tb_contador_descendente;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic         load;
  logic [W-1:0] valor;
  logic         start;
  logic         stop;

  logic [W-1:0] sal_os, sal_ar;
  logic         busy_os, busy_ar;
  logic         tc_os, tc_ar;
  logic         done_os, done_ar;

  int n_checks = 0;
  int n_errors = 0;

  contador_descendente #(.WIDTH(W), .AUTO_RELOAD(0)) u_oneshot (
    .iclk    (clk),
    .irst_n  (rst_n),
    .iCE     (ce),
    .iLoad   (load),
    .iValor  (valor),
    .iStart  (start),
    .iStop   (stop),
    .oSalidas(sal_os),
    .oBusy   (busy_os),
    .oTC     (tc_os),
    .oDone   (done_os)
  );

  contador_descendente #(.WIDTH(W), .AUTO_RELOAD(1)) u_periodic (
    .iclk    (clk),
    .irst_n  (rst_n),
    .iCE     (ce),
    .iLoad   (load),
    .iValor  (valor),
    .iStart  (start),
    .iStop   (stop),
    .oSalidas(sal_ar),
    .oBusy   (busy_ar),
    .oTC     (tc_ar),
    .oDone   (done_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_os(input string tag, input int s, input int b, input int t, input int d);
    check({tag, ".sal"},  32'(sal_os),  32'(s));
    check({tag, ".busy"}, 32'(busy_os), 32'(b));
    check({tag, ".tc"},   32'(tc_os),   32'(t));
    check({tag, ".done"}, 32'(done_os), 32'(d));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load  = 1'b1;
    valor = v;
    tick();
    load  = 1'b0;
  endtask

  int ce_pat  [5] = '{1, 0, 1, 0, 1};
  int ce_exp  [5] = '{2, 2, 1, 1, 0};
  int ar_sal  [8] = '{2, 1, 2, 1, 2, 1, 2, 1};
  int ar_tc   [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  int cycles;

  initial begin
    rst_n = 1'b0; ce = 1'b0; load = 1'b0; valor = '0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check_os("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Start with no prior load: immediate terminal count, single pulse while held.
    start = 1'b1;
    tick();
    check_os("nolоad_start", 0, 0, 1, 1);
    tick();
    check_os("noload_held1", 0, 0, 0, 1);
    tick();
    check_os("noload_held2", 0, 0, 0, 1);
    start = 1'b0;
    tick();

    // Load 5 and count down with CE held high.
    do_load(4'd5);
    check_os("load5", 5, 0, 0, 0);
    start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    check_os("run5_start", 5, 1, 0, 0);
    for (int v = 4; v >= 1; v--) begin
      tick();
      check_os($sformatf("run5_%0d", v), v, 1, 0, 0);
    end
    tick();
    check_os("run5_tc", 0, 0, 1, 1);
    tick();
    check_os("run5_after", 0, 0, 0, 1);
    ce = 1'b0;

    // Load 3 and gate CE.
    do_load(4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_os("ce_start", 3, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ce = ce_pat[i][0];
      tick();
      check_os($sformatf("ce_gate%0d", i), ce_exp[i], (i == 4) ? 0 : 1, (i == 4) ? 1 : 0,
               (i == 4) ? 1 : 0);
    end
    ce = 1'b0;

    // Periodic instance: load 2, reload every second enabled cycle.
    do_load(4'd2);
    start = 1'b1; ce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      check($sformatf("ar_sal%0d", i),  32'(sal_ar),  32'(ar_sal[i]));
      check($sformatf("ar_tc%0d", i),   32'(tc_ar),   32'(ar_tc[i]));
      check($sformatf("ar_busy%0d", i), 32'(busy_ar), 32'd1);
    end
    ce = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("ar_stop_busy", 32'(busy_ar), 32'd0);

    // Stop mid-run, resume, then load beats a simultaneous start.
    do_load(4'd5);
    start = 1'b1; ce = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check_os("pre_stop", 3, 1, 0, 0);
    ce = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    check_os("stopped", 3, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_os("resume", 3, 1, 0, 0);
    ce = 1'b1;
    tick(); check_os("resume_2", 2, 1, 0, 0);
    tick(); check_os("resume_1", 1, 1, 0, 0);
    tick(); check_os("resume_tc", 0, 0, 1, 1);
    ce = 1'b0;
    load = 1'b1; valor = 4'd9; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    check_os("load_wins", 9, 0, 0, 0);
    tick();
    check_os("load_wins_hold", 9, 0, 0, 0);

    // Full-scale value: 15 enabled cycles to terminal count.
    do_load(4'd15);
    start = 1'b1;
    tick();
    start = 1'b0; ce = 1'b1;
    cycles = 0;
    while (tc_os !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    check("allones_cycles", 32'(cycles), 32'd15);
    check_os("allones_end", 0, 0, 1, 1);
    ce = 1'b0;

    // Asynchronous reset mid-count at 7.
    do_load(4'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_os("pre_rst", 7, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_os("async_rst", 0, 0, 0, 0);
    check("async_rst_ar_sal", 32'(sal_ar), 32'd0);
    check("async_rst_ar_busy", 32'(busy_ar), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_os("post_rst", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_contador_descendente
